frame_buffer_manager: RTL

- Triple-buffer index manager in the clk_100Mhz AXI domain.
- Replaces the inline double-buffer swap between the AXI4 writer (camera side) and the AXI4 reader (HDMI side).
- Hands the writer a buffer that is never the one being displayed, and hands the reader the newest completed frame at each display vsync.
- Counts dropped and repeated frames, and flags a stalled camera path.

---
 rtl/frame_buffer_manager_if.sv | 30 +++
 rtl/frame_buffer_manager.sv | 120 ++++++++++++
 2 files changed

// File: rtl/frame_buffer_manager_if.sv
// Handshake and status bundle between the frame-buffer index manager, the
// camera-side AXI writer and the HDMI-side AXI reader.
interface frame_buffer_manager_if #(
  parameter int CNT_W = 16
);
  logic             writer_done;
  logic             vsync_pulse;
  logic [31:0]      w_frame_base_addr;
  logic [31:0]      r_frame_base_addr;
  logic [1:0]       w_buf_idx;
  logic [1:0]       r_buf_idx;
  logic             frame_fresh;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] repeat_cnt;
  logic             writer_stall;

  // Pulse source side (writer/display timing) observing the manager outputs.
  modport master (
    output writer_done, vsync_pulse,
    input  w_frame_base_addr, r_frame_base_addr, w_buf_idx, r_buf_idx,
           frame_fresh, drop_cnt, repeat_cnt, writer_stall
  );

  // Manager side.
  modport slave (
    input  writer_done, vsync_pulse,
    output w_frame_base_addr, r_frame_base_addr, w_buf_idx, r_buf_idx,
           frame_fresh, drop_cnt, repeat_cnt, writer_stall
  );
endinterface

// File: rtl/frame_buffer_manager.sv
// Triple-buffer index manager. The writer always owns a buffer the reader is
// not displaying; at each display vsync the reader takes the newest completed
// frame if one is waiting, otherwise it re-shows the current one.
module frame_buffer_manager #(
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE   = 32'h0010_0000,
  parameter int          STALL_FRAMES = 8,
  parameter int          CNT_W        = 16
) (
  input logic                   clk_100Mhz,
  input logic                   rst,
  frame_buffer_manager_if.slave bus
);

  localparam int                 STALL_W   = $clog2(STALL_FRAMES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_FRAMES);

  function automatic logic [31:0] buf_addr(input logic [1:0] idx);
    return BASE_ADDR + (32'(idx) * BUF_STRIDE);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Registered state: W owned by the writer, R shown by the reader, Y the
  // parked ready buffer, F set while Y holds a completed, undisplayed frame.
  logic [1:0]         w_idx, r_idx, y_idx;
  logic               fresh;
  logic [CNT_W-1:0]   drop_cnt, repeat_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               stall;
  logic [31:0]        w_addr, r_addr;

  // Next-state values
  logic [1:0]         w_nxt, r_nxt, y_nxt;
  logic               fresh_nxt;
  logic               drop_inc, repeat_inc;
  logic [STALL_W-1:0] stall_cnt_nxt;

  // Buffer rotation: writer_done is folded in first, then vsync sees the
  // post-writer view so a coincident pair hands the just-finished frame
  // straight to the reader without counting a repeat.
  always_comb begin
    w_nxt      = w_idx;
    r_nxt      = r_idx;
    y_nxt      = y_idx;
    fresh_nxt  = fresh;
    drop_inc   = 1'b0;
    repeat_inc = 1'b0;
    if (bus.writer_done) begin
      w_nxt     = y_idx;
      y_nxt     = w_idx;
      fresh_nxt = 1'b1;
      drop_inc  = fresh;
    end
    if (bus.vsync_pulse) begin
      if (fresh_nxt) begin
        r_nxt     = y_nxt;
        y_nxt     = r_idx;
        fresh_nxt = 1'b0;
      end else begin
        repeat_inc = 1'b1;
      end
    end
  end

  // Camera stall watchdog: writer_done wins over a coincident vsync.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (bus.writer_done) begin
      stall_cnt_nxt = '0;
    end else if (bus.vsync_pulse && (stall_cnt != STALL_MAX)) begin
      stall_cnt_nxt = stall_cnt + STALL_W'(1);
    end
  end

  // State and registered outputs; everything returns to the reset view at once.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      w_idx      <= 2'd0;
      r_idx      <= 2'd1;
      y_idx      <= 2'd2;
      fresh      <= 1'b0;
      drop_cnt   <= '0;
      repeat_cnt <= '0;
      stall_cnt  <= '0;
      stall      <= 1'b0;
      w_addr     <= BASE_ADDR;
      r_addr     <= BASE_ADDR + BUF_STRIDE;
    end else begin
      w_idx     <= w_nxt;
      r_idx     <= r_nxt;
      y_idx     <= y_nxt;
      fresh     <= fresh_nxt;
      stall_cnt <= stall_cnt_nxt;
      stall     <= (stall_cnt_nxt == STALL_MAX);
      w_addr    <= buf_addr(w_nxt);
      r_addr    <= buf_addr(r_nxt);
      if (drop_inc)   drop_cnt   <= sat_inc(drop_cnt);
      if (repeat_inc) repeat_cnt <= sat_inc(repeat_cnt);
    end
  end

  assign bus.w_buf_idx         = w_idx;
  assign bus.r_buf_idx         = r_idx;
  assign bus.w_frame_base_addr = w_addr;
  assign bus.r_frame_base_addr = r_addr;
  assign bus.frame_fresh       = fresh;
  assign bus.drop_cnt          = drop_cnt;
  assign bus.repeat_cnt        = repeat_cnt;
  assign bus.writer_stall      = stall;

  // The writer must never land on the displayed buffer, and the three
  // indices must always stay a permutation of {0,1,2}.
  a_no_collision: assert property (@(posedge clk_100Mhz) disable iff (rst)
    (w_idx != r_idx) && (w_idx != y_idx) && (r_idx != y_idx) &&
    (w_idx != 2'd3) && (r_idx != 2'd3) && (y_idx != 2'd3));

endmodule
